// File: rtl/dispense_sequencer_if.sv
// Order and status bundle between the front panel and the dispense sequencer.
// The front panel drives the order; the sequencer drives the valves and status.
interface dispense_sequencer_if;
    logic       start;
    logic [4:0] recipe;
    logic [1:0] sugar_lvl;
    logic       cancel;
    logic       water;
    logic       coffee;
    logic       sugar;
    logic       milk;
    logic       chocolate;
    logic       busy;
    logic       done;
    logic       aborted;
    logic       error;
    logic [2:0] stage;

    modport master (
        output start, recipe, sugar_lvl, cancel,
        input  water, coffee, sugar, milk, chocolate,
        input  busy, done, aborted, error, stage
    );

    modport slave (
        input  start, recipe, sugar_lvl, cancel,
        output water, coffee, sugar, milk, chocolate,
        output busy, done, aborted, error, stage
    );
endinterface

// File: rtl/dispense_sequencer.sv
// Timed stage sequencer for the beverage dispenser: opens one ingredient valve
// at a time (water, coffee, sugar, milk, chocolate) for a programmed duration.
module dispense_sequencer #(
    parameter int CNT_W    = 8,
    parameter int T_WATER  = 20,
    parameter int T_COFFEE = 10,
    parameter int T_SUGAR  = 5,
    parameter int T_MILK   = 8,
    parameter int T_CHOC   = 6
) (
    input logic                  clock,
    input logic                  reset,
    dispense_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WATER  = 3'd1,
        COFFEE = 3'd2,
        SUGAR  = 3'd3,
        MILK   = 3'd4,
        CHOC   = 3'd5,
        DONE   = 3'd6
    } state_t;

    localparam int MAX_DUR = (1 << CNT_W) - 1;
    localparam logic [CNT_W-1:0] DUR_WATER  = CNT_W'((T_WATER  > MAX_DUR) ? MAX_DUR : T_WATER);
    localparam logic [CNT_W-1:0] DUR_COFFEE = CNT_W'((T_COFFEE > MAX_DUR) ? MAX_DUR : T_COFFEE);
    localparam logic [CNT_W-1:0] DUR_MILK   = CNT_W'((T_MILK   > MAX_DUR) ? MAX_DUR : T_MILK);
    localparam logic [CNT_W-1:0] DUR_CHOC   = CNT_W'((T_CHOC   > MAX_DUR) ? MAX_DUR : T_CHOC);
    localparam logic [CNT_W+1:0] SUGAR_UNIT = (CNT_W+2)'(T_SUGAR);
    localparam logic [CNT_W+1:0] SUGAR_MAX  = (CNT_W+2)'(MAX_DUR);

    state_t           state, state_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [4:0]       mask_q, mask_nx;
    logic [CNT_W-1:0] sdur_q, sdur_nx;
    logic [CNT_W+1:0] sugar_prod;
    logic [CNT_W-1:0] sugar_dur;
    logic [4:0]       eff_mask;
    logic             in_stage;

    function automatic logic [CNT_W-1:0] stage_dur(input state_t st, input logic [CNT_W-1:0] sdur);
        case (st)
            WATER:   return DUR_WATER;
            COFFEE:  return DUR_COFFEE;
            SUGAR:   return sdur;
            MILK:    return DUR_MILK;
            CHOC:    return DUR_CHOC;
            default: return '0;
        endcase
    endfunction

    // First enabled stage strictly after cur in dispense order, else DONE.
    function automatic state_t next_stage(input logic [2:0] cur, input logic [4:0] m);
        state_t r;
        r = DONE;
        for (int i = 5; i >= 1; i--) begin
            if (i > int'(cur) && m[i-1]) begin
                r = state_t'(i[2:0]);
            end
        end
        return r;
    endfunction

    // Sugar time scales with the requested units; zero-length stages drop out of the order.
    always_comb begin
        sugar_prod = {{CNT_W{1'b0}}, bus.sugar_lvl} * SUGAR_UNIT;
        sugar_dur  = (sugar_prod > SUGAR_MAX) ? '1 : sugar_prod[CNT_W-1:0];
        eff_mask   = bus.recipe;
        if (DUR_WATER  == '0) eff_mask[0] = 1'b0;
        if (DUR_COFFEE == '0) eff_mask[1] = 1'b0;
        if (sugar_dur  == '0) eff_mask[2] = 1'b0;
        if (DUR_MILK   == '0) eff_mask[3] = 1'b0;
        if (DUR_CHOC   == '0) eff_mask[4] = 1'b0;
    end

    assign in_stage = (state >= WATER) && (state <= CHOC);

    always_comb begin
        state_nx = state;
        count_nx = count;
        mask_nx  = mask_q;
        sdur_nx  = sdur_q;
        case (state)
            IDLE: begin
                if (bus.start && !bus.cancel && eff_mask != '0) begin
                    mask_nx  = eff_mask;
                    sdur_nx  = sugar_dur;
                    state_nx = next_stage(IDLE, eff_mask);
                    count_nx = stage_dur(state_nx, sugar_dur) - CNT_W'(1);
                end
            end
            WATER, COFFEE, SUGAR, MILK, CHOC: begin
                if (bus.cancel) begin
                    state_nx = IDLE;
                    count_nx = '0;
                end else if (count == '0) begin
                    state_nx = next_stage(state, mask_q);
                    count_nx = (state_nx == DONE) ? '0 : stage_dur(state_nx, sdur_q) - CNT_W'(1);
                end else begin
                    count_nx = count - CNT_W'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: begin
                state_nx = IDLE;
                count_nx = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            count         <= '0;
            mask_q        <= '0;
            sdur_q        <= '0;
            bus.water     <= 1'b0;
            bus.coffee    <= 1'b0;
            bus.sugar     <= 1'b0;
            bus.milk      <= 1'b0;
            bus.chocolate <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.aborted   <= 1'b0;
            bus.error     <= 1'b0;
            bus.stage     <= 3'd0;
        end else begin
            state         <= state_nx;
            count         <= count_nx;
            mask_q        <= mask_nx;
            sdur_q        <= sdur_nx;
            bus.water     <= (state_nx == WATER);
            bus.coffee    <= (state_nx == COFFEE);
            bus.sugar     <= (state_nx == SUGAR);
            bus.milk      <= (state_nx == MILK);
            bus.chocolate <= (state_nx == CHOC);
            bus.busy      <= (state_nx != IDLE);
            bus.done      <= (state_nx == DONE);
            bus.aborted   <= in_stage && bus.cancel;
            bus.error     <= (state == IDLE) && bus.start && !bus.cancel && (eff_mask == '0);
            bus.stage     <= state_nx;
        end
    end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Self-checking bench for dispense_sequencer: a per-cycle schedule model plus
// literal checks pinned to the documented order timings.
module tb_dispense_sequencer;

    localparam int T_WATER  = 20;
    localparam int T_COFFEE = 10;
    localparam int T_SUGAR  = 5;
    localparam int T_MILK   = 8;
    localparam int T_CHOC   = 6;

    logic clock;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    bit   check_en = 0;

    dispense_sequencer_if bus ();

    dispense_sequencer #(
        .CNT_W    (8),
        .T_WATER  (T_WATER),
        .T_COFFEE (T_COFFEE),
        .T_SUGAR  (T_SUGAR),
        .T_MILK   (T_MILK),
        .T_CHOC   (T_CHOC)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Packed view: {stage, chocolate, milk, sugar, coffee, water, busy, done, aborted, error}
    function automatic logic [11:0] got_vec();
        return {bus.stage, bus.chocolate, bus.milk, bus.sugar, bus.coffee, bus.water,
                bus.busy, bus.done, bus.aborted, bus.error};
    endfunction

    task automatic checkOutput(input string name, input logic [11:0] want);
        logic [11:0] got;
        got = got_vec();
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got stage=%0d valves=%b bsy/dn/ab/er=%b, want stage=%0d valves=%b bsy/dn/ab/er=%b",
                     name, $time, got[11:9], got[8:4], got[3:0], want[11:9], want[8:4], want[3:0]);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic [4:0] r, input logic [1:0] l, input logic c);
        bus.start     = s;
        bus.recipe    = r;
        bus.sugar_lvl = l;
        bus.cancel    = c;
    endtask

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    // Model: an accepted order becomes a list of per-cycle stage codes, consumed one per edge.
    int          plan[$];
    int          exp_stage = 0;
    logic        exp_aborted = 0;
    logic        exp_error = 0;

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            plan.delete();
            exp_stage   = 0;
            exp_aborted = 0;
            exp_error   = 0;
        end else begin
            int dur[5];
            exp_aborted = 0;
            exp_error   = 0;
            if (exp_stage == 0) begin
                if (bus.start && !bus.cancel) begin
                    dur[0] = sat(T_WATER);
                    dur[1] = sat(T_COFFEE);
                    dur[2] = sat(int'(bus.sugar_lvl) * T_SUGAR);
                    dur[3] = sat(T_MILK);
                    dur[4] = sat(T_CHOC);
                    for (int s = 0; s < 5; s++)
                        if (bus.recipe[s])
                            for (int n = 0; n < dur[s]; n++) plan.push_back(s + 1);
                    if (plan.size() == 0) exp_error = 1;
                    else plan.push_back(6);
                end
            end else if (exp_stage <= 5 && bus.cancel) begin
                plan.delete();
                exp_aborted = 1;
            end
            exp_stage = (plan.size() != 0) ? plan.pop_front() : 0;
        end
    end

    function automatic logic [11:0] model_vec();
        logic [4:0] v;
        v = (exp_stage >= 1 && exp_stage <= 5) ? (5'b00001 << (exp_stage - 1)) : 5'b00000;
        return {3'(exp_stage), v, (exp_stage != 0), (exp_stage == 6), exp_aborted, exp_error};
    endfunction

    always @(negedge clock) begin
        if (check_en) checkOutput("model", model_vec());
    end

    localparam logic [11:0] V_IDLE  = 12'b000_00000_0000;
    localparam logic [11:0] V_WATER = {3'd1, 5'b00001, 4'b1000};
    localparam logic [11:0] V_COF   = {3'd2, 5'b00010, 4'b1000};
    localparam logic [11:0] V_SUG   = {3'd3, 5'b00100, 4'b1000};
    localparam logic [11:0] V_MILK  = {3'd4, 5'b01000, 4'b1000};
    localparam logic [11:0] V_CHOC  = {3'd5, 5'b10000, 4'b1000};
    localparam logic [11:0] V_DONE  = {3'd6, 5'b00000, 4'b1100};
    localparam logic [11:0] V_ABORT = {3'd0, 5'b00000, 4'b0010};
    localparam logic [11:0] V_ERR   = {3'd0, 5'b00000, 4'b0001};

    initial begin
        reset = 1'b0;
        applyStimulus(0, 5'b0, 2'd0, 0);
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset_state", V_IDLE);
        @(negedge clock);
        reset = 1'b1;
        check_en = 1;
        stepCycle();

        // Full order with two sugar units
        applyStimulus(1, 5'b11111, 2'd2, 0);
        for (int c = 1; c <= 56; c++) begin
            stepCycle();
            if (c == 1) bus.start = 0;
            case (c)
                1, 20:   checkOutput("full_water", V_WATER);
                21, 30:  checkOutput("full_coffee", V_COF);
                31, 40:  checkOutput("full_sugar", V_SUG);
                41, 48:  checkOutput("full_milk", V_MILK);
                49, 54:  checkOutput("full_choc", V_CHOC);
                55:      checkOutput("full_done", V_DONE);
                56:      checkOutput("full_idle", V_IDLE);
                default: ;
            endcase
        end

        // Sugar requested with zero units is skipped
        applyStimulus(1, 5'b00101, 2'd0, 0);
        for (int c = 1; c <= 22; c++) begin
            stepCycle();
            if (c == 1) bus.start = 0;
            if (c == 20) checkOutput("nosugar_water", V_WATER);
            if (c == 21) checkOutput("nosugar_done", V_DONE);
            if (c == 22) checkOutput("nosugar_idle", V_IDLE);
        end

        // Empty orders are rejected
        applyStimulus(1, 5'b00000, 2'd3, 0);
        stepCycle();
        bus.start = 0;
        checkOutput("empty_error", V_ERR);
        stepCycle();
        checkOutput("empty_after", V_IDLE);
        applyStimulus(1, 5'b00100, 2'd0, 0);
        stepCycle();
        bus.start = 0;
        checkOutput("sugar0_error", V_ERR);
        stepCycle();
        checkOutput("sugar0_after", V_IDLE);

        // Cancel during the third coffee cycle
        applyStimulus(1, 5'b00011, 2'd0, 0);
        for (int c = 1; c <= 25; c++) begin
            stepCycle();
            if (c == 1) bus.start = 0;
            if (c == 23) begin
                checkOutput("cancel_coffee3", V_COF);
                bus.cancel = 1;
            end
            if (c == 24) begin
                checkOutput("cancel_abort", V_ABORT);
                bus.cancel = 0;
            end
            if (c == 25) checkOutput("cancel_idle", V_IDLE);
        end

        // Restart attempt and recipe change mid-order are ignored
        applyStimulus(1, 5'b00001, 2'd0, 0);
        for (int c = 1; c <= 22; c++) begin
            stepCycle();
            if (c == 1) bus.start = 0;
            if (c == 5) applyStimulus(1, 5'b11111, 2'd3, 0);
            if (c == 6) bus.start = 0;
            if (c == 21) checkOutput("restart_done", V_DONE);
            if (c == 22) checkOutput("restart_idle", V_IDLE);
        end

        // Start and cancel together in idle
        applyStimulus(1, 5'b11111, 2'd2, 1);
        stepCycle();
        checkOutput("startcancel_1", V_IDLE);
        stepCycle();
        checkOutput("startcancel_2", V_IDLE);
        applyStimulus(0, 5'b0, 2'd0, 0);

        // Asynchronous reset in the middle of the milk stage
        applyStimulus(1, 5'b01000, 2'd0, 0);
        for (int c = 1; c <= 4; c++) begin
            stepCycle();
            if (c == 1) bus.start = 0;
        end
        checkOutput("midmilk_before", V_MILK);
        #2 reset = 1'b0;
        #1 checkOutput("midmilk_reset", V_IDLE);
        @(negedge clock);
        reset = 1'b1;
        stepCycle();

        applyStimulus(1, 5'b10000, 2'd0, 0);
        for (int c = 1; c <= 8; c++) begin
            stepCycle();
            if (c == 1) bus.start = 0;
            if (c == 1 || c == 6) checkOutput("choc_valve", V_CHOC);
            if (c == 7) checkOutput("choc_done", V_DONE);
            if (c == 8) checkOutput("choc_idle", V_IDLE);
        end

        // Randomized orders, cancels and mid-order noise
        for (int i = 0; i < 4000; i++) begin
            @(negedge clock);
            bus.start     = ($urandom_range(0, 3) == 0);
            bus.recipe    = ($urandom_range(0, 7) == 0) ? 5'b0 : 5'($urandom);
            bus.sugar_lvl = 2'($urandom);
            bus.cancel    = ($urandom_range(0, 39) == 0);
        end
        @(negedge clock);
        applyStimulus(0, 5'b0, 2'd0, 0);
        repeat (3) @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
